// File: rtl/mult_stream_pkg.sv
// Shared types, defaults and width helper for the streaming multiplier.
package mult_stream_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    localparam int DEF_OPW       = 8;
    localparam int DEF_IN_DEPTH  = 16;
    localparam int DEF_OUT_DEPTH = 16;
    localparam int DEF_MULT_LAT  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_p.sv
// Synchronous FIFO with registered read data/valid, count-derived FULL/EMPTY
// and sticky overrun/underrun flags.
module sync_fifo_p
    import mult_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_over,
    output logic             o_under,
    input  logic             i_err_clr
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_over;
    logic             r_under;
    logic             w_push;
    logic             w_pop;

    // Status comes only from the registered count, so a write into a full
    // FIFO is dropped even when a pop happens in the same cycle.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_wr & ~o_full;
    assign w_pop   = i_rd & ~o_empty;

    assign o_count = r_count;
    assign o_dout  = r_dout;
    assign o_valid = r_valid;
    assign o_over  = r_over;
    assign o_under = r_under;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_over  <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_dout <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh error outranks a clear in the same cycle.
            if (i_wr && o_full)      r_over <= 1'b1;
            else if (i_err_clr)      r_over <= 1'b0;
            if (i_rd && o_empty)     r_under <= 1'b1;
            else if (i_err_clr)      r_under <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_stream_pipe.sv
// Streaming multiplier: input FIFO -> MULT_LAT-stage multiplier -> output FIFO,
// with credit-gated popping so the output FIFO can never overflow.
module mult_stream_pipe
    import mult_stream_pkg::*;
#(
    parameter int OPW       = DEF_OPW,
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int MULT_LAT  = DEF_MULT_LAT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2*OPW-1:0] i_din,
    input  logic             i_mode,
    input  logic             i_wr,
    output logic             o_full,
    input  logic             i_rd,
    output logic [2*OPW-1:0] o_dout,
    output logic             o_valid,
    output logic             o_empty,
    output logic             o_over,
    output logic             o_under,
    input  logic             i_err_clr
);

    localparam int DW  = 2 * OPW;
    localparam int ICW = clog2(IN_DEPTH + 1);
    localparam int OCW = clog2(OUT_DEPTH + 1);
    localparam int SCW = clog2(OUT_DEPTH + MULT_LAT + 2);

    logic [DW:0]      w_s0_word;
    logic             w_s0_vld;
    logic             w_in_empty;
    logic [ICW-1:0]   w_in_count;
    logic             w_in_under;
    logic             w_pop;

    logic [OPW-1:0]   w_s0_a;
    logic [OPW-1:0]   w_s0_b;
    logic [DW-1:0]    w_a_ext;
    logic [DW-1:0]    w_b_ext;
    logic [DW-1:0]    w_prod;

    logic [MULT_LAT-1:0] r_pvld;
    logic [DW-1:0]       r_pdat [MULT_LAT];

    logic [SCW-1:0]   w_inflight;
    logic             w_credit_ok;
    logic [OCW-1:0]   w_out_count;
    logic             w_out_full;
    logic             w_out_over;
    logic             w_unused;

    sync_fifo_p #(
        .WIDTH (DW + 1),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (i_wr),
        .i_din     ({i_mode, i_din}),
        .o_full    (o_full),
        .i_rd      (w_pop),
        .o_dout    (w_s0_word),
        .o_valid   (w_s0_vld),
        .o_empty   (w_in_empty),
        .o_count   (w_in_count),
        .o_over    (o_over),
        .o_under   (w_in_under),
        .i_err_clr (i_err_clr)
    );

    // Every word already in flight holds a reserved output slot.
    always_comb begin
        w_inflight = SCW'(w_s0_vld);
        for (int k = 0; k < MULT_LAT; k++) begin
            w_inflight = w_inflight + SCW'(r_pvld[k]);
        end
    end

    assign w_credit_ok = (SCW'(w_out_count) + w_inflight) < SCW'(OUT_DEPTH);
    assign w_pop       = ~w_in_empty & w_credit_ok;

    assign w_s0_a  = w_s0_word[DW-1:OPW];
    assign w_s0_b  = w_s0_word[OPW-1:0];
    // Extending to full width makes one modular multiply serve both modes.
    assign w_a_ext = (w_s0_word[DW] == MODE_SIGNED) ? {{OPW{w_s0_a[OPW-1]}}, w_s0_a}
                                                    : {{OPW{1'b0}}, w_s0_a};
    assign w_b_ext = (w_s0_word[DW] == MODE_SIGNED) ? {{OPW{w_s0_b[OPW-1]}}, w_s0_b}
                                                    : {{OPW{1'b0}}, w_s0_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pvld <= '0;
            for (int k = 0; k < MULT_LAT; k++) r_pdat[k] <= '0;
        end else begin
            r_pvld[0] <= w_s0_vld;
            r_pdat[0] <= w_prod;
            for (int k = 1; k < MULT_LAT; k++) begin
                r_pvld[k] <= r_pvld[k-1];
                r_pdat[k] <= r_pdat[k-1];
            end
        end
    end

    sync_fifo_p #(
        .WIDTH (DW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (r_pvld[MULT_LAT-1]),
        .i_din     (r_pdat[MULT_LAT-1]),
        .o_full    (w_out_full),
        .i_rd      (i_rd),
        .o_dout    (o_dout),
        .o_valid   (o_valid),
        .o_empty   (o_empty),
        .o_count   (w_out_count),
        .o_over    (w_out_over),
        .o_under   (o_under),
        .i_err_clr (i_err_clr)
    );

    // Input underrun and output overrun cannot occur thanks to the pop gating.
    assign w_unused = ^{w_in_count, w_in_under, w_out_full, w_out_over};

endmodule

// File: tb/tb_mult_stream_pipe.sv
// Bench for mult_stream_pipe: directed cases plus a random full-rate stream
// checked against a queue-based timing/arithmetic model.
module tb_mult_stream_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic        mode = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        err_clr = 1'b0;
    logic        o_full;
    logic [15:0] o_dout;
    logic        o_valid;
    logic        o_empty;
    logic        o_over;
    logic        o_under;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_stream_pipe #(
        .OPW       (8),
        .IN_DEPTH  (16),
        .OUT_DEPTH (16),
        .MULT_LAT  (2)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_din     (din),
        .i_mode    (mode),
        .i_wr      (wr),
        .o_full    (o_full),
        .i_rd      (rd),
        .o_dout    (o_dout),
        .o_valid   (o_valid),
        .o_empty   (o_empty),
        .o_over    (o_over),
        .o_under   (o_under),
        .i_err_clr (err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic on the operands, truncated to the output width.
    function automatic logic [15:0] ref_prod(input logic [15:0] d, input logic m);
        int a, b, p;
        a = int'(d[15:8]);
        b = int'(d[7:0]);
        if (m) begin
            if (a > 127) a -= 256;
            if (b > 127) b -= 256;
        end
        p = a * b;
        return p[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nonempty(input string name);
        int n;
        n = 0;
        while (o_empty && n < 40) begin
            step();
            n++;
        end
        if (o_empty) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic read_one(input logic [15:0] d, input logic m,
                            input logic [15:0] exp, input string name);
        din = d; mode = m; wr = 1'b1;
        step();
        wr = 1'b0;
        wait_nonempty(name);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk({name, "_valid"}, 32'(o_valid), 32'd1);
        chk({name, "_dout"}, 32'(o_dout), 32'(exp));
    endtask

    typedef struct {
        int          wedge;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    bit   model_on = 1'b0;
    int   n_val = 0;
    int   first_v = -1;
    int   last_v = -1;

    // A word written at edge e is readable by an RD sampled at edge e+5
    // (pipeline never stalls while the consumer reads every cycle).
    always @(posedge clk) begin : compare
        bit          on, sw, sr, sm, ev;
        logic [15:0] sd;
        int          e;
        edge_n++;
        e  = edge_n;
        on = model_on;
        sw = wr;
        sr = rd;
        sm = mode;
        sd = din;
        #1;
        if (on) begin
            ev = sr && (exp_q.size() > 0) && (exp_q[0].wedge + 5 <= e);
            chk("stream_valid", 32'(o_valid), 32'(ev));
            if (ev) begin
                chk("stream_dout", 32'(o_dout), 32'(exp_q[0].val));
                void'(exp_q.pop_front());
                n_val++;
                if (first_v < 0) first_v = e;
                last_v = e;
            end
            chk("stream_full", 32'(o_full), 32'd0);
            chk("stream_over", 32'(o_over), 32'd0);
            if (sw) exp_q.push_back('{e, ref_prod(sd, sm)});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc;

        #3;
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_dout",  32'(o_dout),  32'd0);
        chk("rst_over",  32'(o_over),  32'd0);
        chk("rst_under", 32'(o_under), 32'd0);
        #19 rst_n = 1'b1;
        step();

        chk("model_pin_signed",   32'(ref_prod(16'hFF03, 1'b1)), 32'h0000_FFFD);
        chk("model_pin_unsigned", 32'(ref_prod(16'hFF03, 1'b0)), 32'h0000_02FD);

        // Idle latency from write edge to EMPTY falling.
        din = 16'h0305; mode = 1'b0; wr = 1'b1;
        step();
        wr = 1'b0;
        n = 0;
        while (o_empty && n < 20) begin
            step();
            n++;
        end
        chk("latency_edges", 32'(n), 32'd4);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("first_valid", 32'(o_valid), 32'd1);
        chk("first_dout",  32'(o_dout),  32'h000F);
        step();
        chk("valid_pulse", 32'(o_valid), 32'd0);

        read_one(16'hFF03, 1'b1, 16'hFFFD, "signed_mul");
        read_one(16'hFF03, 1'b0, 16'h02FD, "unsigned_mul");

        // Backpressure: consumer stalled, 40 writes offered.
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            din = {8'(i), 8'h01}; mode = 1'b0; wr = 1'b1;
            if (!o_full) acc++;
            step();
        end
        wr = 1'b0;
        repeat (8) step();
        chk("bp_accepted", 32'(acc), 32'd32);
        chk("bp_full",  32'(o_full),  32'd1);
        chk("bp_over",  32'(o_over),  32'd1);
        chk("bp_empty", 32'(o_empty), 32'd0);
        rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("drain_valid", 32'(o_valid), 32'd1);
            chk("drain_dout",  32'(o_dout),  32'(i));
        end
        rd = 1'b0;
        chk("drain_empty", 32'(o_empty), 32'd1);
        step();
        chk("drain_valid_end", 32'(o_valid), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("over_cleared", 32'(o_over), 32'd0);

        // Underrun and clear priority.
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("under_valid", 32'(o_valid), 32'd0);
        chk("under_set",   32'(o_under), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("under_cleared", 32'(o_under), 32'd0);
        err_clr = 1'b1; rd = 1'b1;
        step();
        err_clr = 1'b0; rd = 1'b0;
        chk("under_clr_priority", 32'(o_under), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Full-rate random stream, both modes.
        model_on = 1'b1;
        rd = 1'b1;
        wr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            din  = 16'($urandom);
            mode = 1'($urandom_range(0, 1));
            step();
        end
        wr = 1'b0;
        repeat (10) step();
        model_on = 1'b0;
        rd = 1'b0;
        chk("stream_leftover", 32'(exp_q.size()), 32'd0);
        chk("stream_count", 32'(n_val), 32'd200);
        chk("stream_continuous", 32'(last_v - first_v + 1), 32'd200);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Asynchronous reset with data in flight.
        for (int i = 0; i < 10; i++) begin
            din = {8'd3, 8'(i + 2)}; mode = 1'b0; wr = 1'b1;
            step();
        end
        wr = 1'b0;
        repeat (5) step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("pre_rst_dout", 32'(o_dout), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_full",  32'(o_full),  32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_dout",  32'(o_dout),  32'd0);
        #3 rst_n = 1'b1;
        step();
        read_one(16'h0707, 1'b0, 16'h0031, "post_rst");
        repeat (8) step();
        chk("no_stale_empty", 32'(o_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
